// File: rtl/conv_stream_ctrl.sv
`timescale 1ns/1ps
// Column feeder / result collector for the 3x3 convolutor.
// Ports: i_CLK, i_reset (sync, active-high); i_start, i_kernel_mode, i_width
//   start an operation; o_mem_en/o_mem_addr/i_mem_data0..2 read the line buffer;
//   o_dato0..2/o_selecK_I/o_valid push columns; i_conv_data is the convolutor
//   output; o_result/o_result_addr/o_result_valid emit windows; o_busy, o_done.
module conv_stream_ctrl #(
    parameter int BIT_LEN   = 8,
    parameter int M_LEN     = 3,
    parameter int CONV_LPOS = 13,
    parameter int ADDR_LEN  = 11
) (
    input  logic                 i_CLK,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_kernel_mode,
    input  logic [ADDR_LEN-1:0]  i_width,
    output logic                 o_mem_en,
    output logic [ADDR_LEN-1:0]  o_mem_addr,
    input  logic [BIT_LEN-1:0]   i_mem_data0,
    input  logic [BIT_LEN-1:0]   i_mem_data1,
    input  logic [BIT_LEN-1:0]   i_mem_data2,
    output logic [BIT_LEN-1:0]   o_dato0,
    output logic [BIT_LEN-1:0]   o_dato1,
    output logic [BIT_LEN-1:0]   o_dato2,
    output logic                 o_selecK_I,
    output logic                 o_valid,
    input  logic [CONV_LPOS-1:0] i_conv_data,
    output logic [CONV_LPOS-1:0] o_result,
    output logic [ADDR_LEN-1:0]  o_result_addr,
    output logic                 o_result_valid,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PUSH,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int CW = ADDR_LEN + 1;
    // The convolutor output lags one push, so the first full window
    // is readable after push number M_LEN has been counted.
    localparam logic [CW-1:0] FIRST_RES = CW'(M_LEN + 1);

    state_t state;
    state_t state_nx;

    logic                kmode;
    logic [ADDR_LEN-1:0] w;
    logic [ADDR_LEN-1:0] col;
    logic                phase;
    logic [CW-1:0]       push_cnt;
    logic                valid_d;

    // Compare in one extra bit so W = 2^ADDR_LEN-1 cannot wrap.
    logic [CW-1:0] col_inc;
    logic          last;
    logic          res_hit;

    assign col_inc = {1'b0, col} + CW'(1);
    assign last    = (col_inc == {1'b0, w});
    assign res_hit = o_result_valid
                   && (o_result_addr == w - ADDR_LEN'(M_LEN));

    assign o_mem_addr = col;

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        o_mem_en = 1'b0;
        o_busy   = 1'b1;
        o_done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    if (!i_kernel_mode
                        && (i_width < ADDR_LEN'(M_LEN))) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_READ;
                    end
                end
            end
            S_READ: begin
                o_mem_en = 1'b1;
                state_nx = S_PUSH;
            end
            S_PUSH: begin
                if (!last) begin
                    state_nx = S_READ;
                end else if (kmode) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_FLUSH;
                end
            end
            // Two cycles here keep the flush push off the cycle
            // right after the last real push.
            S_FLUSH: begin
                if (phase) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_hit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                o_done   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            kmode          <= 1'b0;
            w              <= '0;
            col            <= '0;
            phase          <= 1'b0;
            push_cnt       <= '0;
            valid_d        <= 1'b0;
            o_dato0        <= '0;
            o_dato1        <= '0;
            o_dato2        <= '0;
            o_selecK_I     <= 1'b0;
            o_valid        <= 1'b0;
            o_result       <= '0;
            o_result_addr  <= '0;
            o_result_valid <= 1'b0;
        end else begin
            o_valid        <= 1'b0;
            o_result_valid <= 1'b0;
            valid_d        <= o_valid;

            if (o_valid) begin
                push_cnt <= push_cnt + CW'(1);
            end

            if (state == S_IDLE && i_start) begin
                kmode    <= i_kernel_mode;
                w        <= i_kernel_mode ? ADDR_LEN'(M_LEN) : i_width;
                col      <= '0;
                phase    <= 1'b0;
                push_cnt <= '0;
            end

            if (state == S_PUSH) begin
                o_dato0    <= i_mem_data0;
                o_dato1    <= i_mem_data1;
                o_dato2    <= i_mem_data2;
                o_selecK_I <= ~kmode;
                o_valid    <= 1'b1;
                col        <= col_inc[ADDR_LEN-1:0];
            end

            if (state == S_FLUSH) begin
                phase <= ~phase;
                if (phase) begin
                    o_dato0    <= '0;
                    o_dato1    <= '0;
                    o_dato2    <= '0;
                    o_selecK_I <= 1'b1;
                    o_valid    <= 1'b1;
                end
            end

            if (state == S_DONE) begin
                col <= '0;
            end

            // Convolutor output is offset binary; flip the MSB back.
            if (valid_d && !kmode && (push_cnt >= FIRST_RES)) begin
                o_result <= {~i_conv_data[CONV_LPOS-1],
                             i_conv_data[CONV_LPOS-2:0]};
                o_result_addr  <= ADDR_LEN'(push_cnt - FIRST_RES);
                o_result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
`timescale 1ns/1ps
// Directed bench for conv_stream_ctrl with a BRAM model and a
// convolutor stub (identity kernel or table-driven output).
module tb_conv_stream_ctrl;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        i_kernel_mode;
    logic [10:0] i_width;
    logic        o_mem_en;
    logic [10:0] o_mem_addr;
    logic [7:0]  i_mem_data0, i_mem_data1, i_mem_data2;
    logic [7:0]  o_dato0, o_dato1, o_dato2;
    logic        o_selecK_I;
    logic        o_valid;
    logic [12:0] i_conv_data;
    logic [12:0] o_result;
    logic [10:0] o_result_addr;
    logic        o_result_valid;
    logic        o_busy;
    logic        o_done;

    conv_stream_ctrl dut (
        .i_CLK          (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_kernel_mode  (i_kernel_mode),
        .i_width        (i_width),
        .o_mem_en       (o_mem_en),
        .o_mem_addr     (o_mem_addr),
        .i_mem_data0    (i_mem_data0),
        .i_mem_data1    (i_mem_data1),
        .i_mem_data2    (i_mem_data2),
        .o_dato0        (o_dato0),
        .o_dato1        (o_dato1),
        .o_dato2        (o_dato2),
        .o_selecK_I     (o_selecK_I),
        .o_valid        (o_valid),
        .i_conv_data    (i_conv_data),
        .o_result       (o_result),
        .o_result_addr  (o_result_addr),
        .o_result_valid (o_result_valid),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: one cycle read latency
    logic [7:0] m0 [16];
    logic [7:0] m1 [16];
    logic [7:0] m2 [16];
    always @(posedge clk) begin
        if (o_mem_en) begin
            i_mem_data0 <= m0[o_mem_addr[3:0]];
            i_mem_data1 <= m1[o_mem_addr[3:0]];
            i_mem_data2 <= m2[o_mem_addr[3:0]];
        end
    end

    // Convolutor stub: after push p, output holds window p-3,
    // whose centre column is p-2 (h2). Table mode indexes by push count.
    logic [7:0]  h0, h1, h2;
    logic [3:0]  pk;
    logic        tab_mode;
    logic [12:0] tab [16];
    always @(posedge clk) begin
        if (i_start && !o_busy) pk <= 4'd0;
        else if (o_valid) pk <= pk + 4'd1;
        if (o_valid) begin
            h0 <= o_dato1;
            h1 <= h0;
            h2 <= h1;
        end
    end
    assign i_conv_data = tab_mode ? tab[pk]
                                  : ({5'b0, h2} ^ 13'h1000);

    // Monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          nval = 0, ncons = 0, nk = 0, nres = 0;
    int          ndone = 0, nrd = 0, done_cyc = 0;
    logic        prev_valid = 1'b0;
    int          vcyc [64];
    logic [7:0]  d0q [64], d1q [64], d2q [64];
    logic        skq [64];
    logic [12:0] rq [64];
    logic [10:0] raq [64];
    int          rcyc [64];
    logic [10:0] mq [64];

    always @(negedge clk) begin
        if (o_valid) begin
            if (prev_valid) ncons++;
            if (!o_selecK_I) nk++;
            vcyc[nval % 64] = cyc;
            d0q[nval % 64]  = o_dato0;
            d1q[nval % 64]  = o_dato1;
            d2q[nval % 64]  = o_dato2;
            skq[nval % 64]  = o_selecK_I;
            nval++;
        end
        prev_valid = o_valid;
        if (o_result_valid) begin
            rq[nres % 64]   = o_result;
            raq[nres % 64]  = o_result_addr;
            rcyc[nres % 64] = cyc;
            nres++;
        end
        if (o_done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (o_mem_en) begin
            mq[nrd % 64] = o_mem_addr;
            nrd++;
        end
    end

    int nchk = 0;
    int nerr = 0;
    int b_val, b_res, b_done, b_rd, b_k, b_cons;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_val  = nval;
        b_res  = nres;
        b_done = ndone;
        b_rd   = nrd;
        b_k    = nk;
        b_cons = ncons;
    endtask

    task automatic start_op(input logic km, input logic [10:0] wd);
        @(negedge clk);
        i_start       = 1'b1;
        i_kernel_mode = km;
        i_width       = wd;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (!o_done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, (n < maxc)}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_image5(input string tag, input int exp_vals[3]);
        check({tag, "_pushes"}, nval - b_val, 6);
        check({tag, "_results"}, nres - b_res, 3);
        check({tag, "_done"}, ndone - b_done, 1);
        check({tag, "_kcols"}, nk - b_k, 0);
        check({tag, "_spacing"}, ncons - b_cons, 0);
        for (int i = 0; i < 5; i++)
            check({tag, "_maddr"}, {21'b0, mq[(b_rd + i) % 64]}, i);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_res"}, {19'b0, rq[(b_res + i) % 64]},
                  exp_vals[i]);
            check({tag, "_raddr"}, {21'b0, raq[(b_res + i) % 64]}, i);
        end
    endtask

    initial begin
        int exp20[3];
        int expfmt[3];
        exp20  = '{20, 30, 40};
        expfmt = '{0, 13'h1FFF, 20};
        i_reset       = 1'b1;
        i_start       = 1'b0;
        i_kernel_mode = 1'b0;
        i_width       = 11'd0;
        tab_mode      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m0[i]  = 8'd0;
            m1[i]  = 8'd0;
            m2[i]  = 8'd0;
            tab[i] = 13'd0;
        end
        repeat (3) @(negedge clk);
        check("rst_ctl", {26'b0, o_mem_en, o_selecK_I, o_valid,
                          o_result_valid, o_busy, o_done}, 0);
        check("rst_dato", {8'b0, o_dato0, o_dato1, o_dato2}, 0);
        check("rst_res", {8'b0, o_result, o_result_addr}, 0);
        check("rst_maddr", {21'b0, o_mem_addr}, 0);
        i_reset = 1'b0;
        @(negedge clk);

        // 1: kernel load
        m1[1] = 8'h40;
        snap();
        start_op(1'b1, 11'd0);
        wait_done("k_timeout", 100);
        check("k_pushes", nval - b_val, 3);
        check("k_kcols", nk - b_k, 3);
        check("k_results", nres - b_res, 0);
        check("k_done", ndone - b_done, 1);
        check("k_spacing", ncons - b_cons, 0);
        check("k_gap", vcyc[(b_val + 1) % 64] - vcyc[b_val % 64], 2);
        check("k_mid", {24'b0, d1q[(b_val + 1) % 64]}, 8'h40);
        check("k_done_time", done_cyc, vcyc[(b_val + 2) % 64]);
        check("k_idle", {31'b0, o_busy}, 0);

        // 2: image W=5
        for (int i = 0; i < 5; i++) m1[i] = 8'(10 * (i + 1));
        snap();
        start_op(1'b0, 11'd5);
        wait_done("i_timeout", 200);
        check_image5("img", exp20);
        check("img_flush", {7'b0, d0q[(b_val + 5) % 64],
                            d1q[(b_val + 5) % 64],
                            d2q[(b_val + 5) % 64], skq[(b_val + 5) % 64]},
              1);
        check("img_rlat", rcyc[b_res % 64], vcyc[(b_val + 3) % 64] + 2);
        check("img_done_time", done_cyc, rcyc[(b_res + 2) % 64] + 1);

        // 3: output format via table stub
        tab[4]   = 13'h1000;
        tab[5]   = 13'h0FFF;
        tab[6]   = 13'h1014;
        tab_mode = 1'b1;
        snap();
        start_op(1'b0, 11'd5);
        wait_done("f_timeout", 200);
        check_image5("fmt", expfmt);
        tab_mode = 1'b0;

        // 4: W=3 then W=2
        snap();
        start_op(1'b0, 11'd3);
        wait_done("w3_timeout", 200);
        check("w3_pushes", nval - b_val, 4);
        check("w3_results", nres - b_res, 1);
        check("w3_addr", {21'b0, raq[b_res % 64]}, 0);
        check("w3_res", {19'b0, rq[b_res % 64]}, 20);
        snap();
        start_op(1'b0, 11'd2);
        wait_done("w2_timeout", 50);
        check("w2_pushes", nval - b_val, 0);
        check("w2_results", nres - b_res, 0);
        check("w2_reads", nrd - b_rd, 0);
        check("w2_done", ndone - b_done, 1);

        // 5: start while busy is ignored
        snap();
        start_op(1'b0, 11'd5);
        repeat (3) @(negedge clk);
        i_start       = 1'b1;
        i_kernel_mode = 1'b1;
        i_width       = 11'd2;
        @(negedge clk);
        i_start = 1'b0;
        wait_done("b_timeout", 200);
        check_image5("busy", exp20);

        // 6: reset after two results
        snap();
        start_op(1'b0, 11'd5);
        for (int n = 0; n < 200 && nres < b_res + 2; n++)
            @(negedge clk);
        check("r_two_res", nres - b_res, 2);
        i_reset = 1'b1;
        @(negedge clk);
        check("r_ctl", {26'b0, o_mem_en, o_selecK_I, o_valid,
                        o_result_valid, o_busy, o_done}, 0);
        check("r_dato", {8'b0, o_dato0, o_dato1, o_dato2}, 0);
        check("r_res", {8'b0, o_result, o_result_addr}, 0);
        check("r_maddr", {21'b0, o_mem_addr}, 0);
        i_reset = 1'b0;
        repeat (8) @(negedge clk);
        check("r_nodone", ndone - b_done, 0);
        check("r_nores", nres - b_res, 2);
        snap();
        start_op(1'b0, 11'd5);
        wait_done("r2_timeout", 200);
        check_image5("rerun", exp20);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
